// File: rtl/bicubic_tap_feeder.sv
// ---------------------------------------------------------------------------
// bicubic_tap_feeder
//
// Source-side window generator for 4-tap bicubic weight tables. One
// horizontal line of 8-bit pixels arrives over a valid/ready stream. For
// every source position x the window {p[x-1], p[x], p[x+1], p[x+2]} is
// presented on tap_0..tap_3, and it is repeated SCALE times (once per
// interpolation phase, reported on out_phase).
//
// A line of N real pixels produces N+2 window pushes: the N pixels plus two
// right-edge pad pushes after in_last. The result is exactly N windows.
//
// Configuration macro:
//   TAP_FEEDER_ZERO_EDGE_EN  defined   -> left and right pads are 8'd0
//                            undefined -> edge replication (left pad = p0,
//                                         right pad = last window tap)
//   Push counts and timing are the same in both builds.
//
// Ports:
//   clk        in   1        clock, all logic on posedge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        input pixel valid
//   in_ready   out  1        feeder accepts a pixel this cycle
//   in_data    in   8        source pixel
//   in_last    in   1        final pixel of the line
//   out_valid  out  1        window + phase valid
//   out_ready  in   1        downstream accepts the window
//   tap_0..3   out  8        window taps p[x-1], p[x], p[x+1], p[x+2]
//   out_phase  out  PHASE_W  interpolation phase 0..SCALE-1
//   out_last   out  1        final phase of the final window of the line
// ---------------------------------------------------------------------------
module bicubic_tap_feeder #(
    parameter int SCALE   = 4,
    parameter int PHASE_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         tap_0,
    output logic [7:0]         tap_1,
    output logic [7:0]         tap_2,
    output logic [7:0]         tap_3,
    output logic [PHASE_W-1:0] out_phase,
    output logic               out_last
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(SCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        EMIT,
        FETCH
    } state_t;

    state_t             state, state_n;
    logic [1:0]         cnt, cnt_n;             // pushes made so far while filling
    logic               ended, ended_n;         // in_last already accepted
    logic [1:0]         pads_left, pads_left_n; // right-edge pad pushes still owed
    logic [PHASE_W-1:0] phase, phase_n;
    logic [7:0]         w0, w1, w2, w3;

    logic               do_push;
    logic               do_first;
    logic [7:0]         push_val;
    logic [7:0]         left_pad;
    logic [7:0]         right_pad;

`ifdef TAP_FEEDER_ZERO_EDGE_EN
    assign left_pad  = 8'd0;
    assign right_pad = 8'd0;
`else
    assign left_pad  = in_data;   // the first push carries p0
    assign right_pad = w3;        // w3 holds the last real pixel (or a copy of it)
`endif

    assign tap_0     = w0;
    assign tap_1     = w1;
    assign tap_2     = w2;
    assign tap_3     = w3;
    assign out_phase = phase;

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can leave a latch behind.
        state_n     = state;
        cnt_n       = cnt;
        ended_n     = ended;
        pads_left_n = pads_left;
        phase_n     = phase;
        do_push     = 1'b0;
        do_first    = 1'b0;
        push_val    = in_data;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;

        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    do_push     = 1'b1;
                    do_first    = 1'b1;
                    cnt_n       = 2'd1;
                    ended_n     = in_last;
                    pads_left_n = in_last ? 2'd2 : 2'd0;
                    phase_n     = '0;
                    state_n     = FILL;
                end
            end

            FILL: begin
                if (!ended) begin
                    in_ready = !rst;
                    if (in_valid && !rst) begin
                        do_push = 1'b1;
                        cnt_n   = cnt + 2'd1;
                        if (in_last) begin
                            ended_n     = 1'b1;
                            pads_left_n = 2'd2;
                        end
                    end
                end else begin
                    // Line already ended: pad pushes complete the first window
                    // and are charged against the two owed right-edge pads.
                    do_push     = 1'b1;
                    push_val    = right_pad;
                    cnt_n       = cnt + 2'd1;
                    pads_left_n = pads_left - 2'd1;
                end
                // The third push completes the first window.
                if (do_push && cnt == 2'd2) begin
                    phase_n = '0;
                    state_n = EMIT;
                end
            end

            EMIT: begin
                out_valid = 1'b1;
                out_last  = ended && (pads_left == 2'd0) && (phase == LAST_PHASE);
                if (out_ready) begin
                    if (phase != LAST_PHASE) begin
                        phase_n = phase + PHASE_W'(1);
                    end else begin
                        phase_n = '0;
                        if (!ended) begin
                            state_n = FETCH;
                        end else if (pads_left != 2'd0) begin
                            do_push     = 1'b1;
                            push_val    = right_pad;
                            pads_left_n = pads_left - 2'd1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end

            FETCH: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    do_push     = 1'b1;
                    ended_n     = in_last;
                    pads_left_n = in_last ? 2'd2 : 2'd0;
                    phase_n     = '0;
                    state_n     = EMIT;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // State, counters and window register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this clock edge.
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            ended     <= 1'b0;
            pads_left <= 2'd0;
            phase     <= '0;
            w0        <= 8'd0;
            w1        <= 8'd0;
            w2        <= 8'd0;
            w3        <= 8'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ended     <= ended_n;
            pads_left <= pads_left_n;
            phase     <= phase_n;
            if (do_push) begin
                if (do_first) begin
                    w0 <= left_pad;
                    w1 <= left_pad;
                    w2 <= left_pad;
                    w3 <= push_val;
                end else begin
                    w0 <= w1;
                    w1 <= w2;
                    w2 <= w3;
                    w3 <= push_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_bicubic_tap_feeder.sv
// ---------------------------------------------------------------------------
// tb_bicubic_tap_feeder
//
// Self-checking bench for bicubic_tap_feeder. Expected beats are derived
// from the line itself: window x is {p(x-1), p(x), p(x+1), p(x+2)} with
// out-of-range indices replaced by the edge pad, each window repeated for
// phases 0..SCALE-1, out_last only on the final phase of the final window.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bicubic_tap_feeder;

    localparam int SCALE   = 4;
    localparam int PHASE_W = 2;

`ifdef TAP_FEEDER_ZERO_EDGE_EN
    localparam bit ZERO_EDGE = 1'b1;
`else
    localparam bit ZERO_EDGE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [7:0]         in_data = 8'd0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [7:0]         tap_0, tap_1, tap_2, tap_3;
    logic [PHASE_W-1:0] out_phase;
    logic               out_last;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] line_px[$];

    always #5 clk = ~clk;

    bicubic_tap_feeder #(
        .SCALE   (SCALE),
        .PHASE_W (PHASE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tap_0     (tap_0),
        .tap_1     (tap_1),
        .tap_2     (tap_2),
        .tap_3     (tap_3),
        .out_phase (out_phase),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Pixel at source index i of the current line, with edge padding.
    function automatic logic [7:0] px_at(input int i);
        int n;
        n = line_px.size();
        if (i < 0)  return ZERO_EDGE ? 8'd0 : line_px[0];
        if (i >= n) return ZERO_EDGE ? 8'd0 : line_px[n-1];
        return line_px[i];
    endfunction

    // Stream line_px through the DUT and check every presented beat.
    // ready_mode: 0 = out_ready always 1, 1 = toggling, 2 = random.
    // gap_pct: chance (percent) of holding in_valid low on a cycle.
    // abort_beat: >=0 pulses rst when that beat index is due.
    task automatic run_line(input int ready_mode, input int gap_pct, input int abort_beat);
        int n;
        int total;
        int sent;
        int beats;
        int cyc;
        int x;
        int ph;
        n     = line_px.size();
        total = n * SCALE;
        sent  = 0;
        beats = 0;
        cyc   = 0;
        while (beats < total && cyc < 40 * total + 50) begin
            @(negedge clk);
            cyc++;
            if (abort_beat >= 0 && beats == abort_beat) begin
                rst       = 1'b1;
                in_valid  = 1'b0;
                in_last   = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("abort_out_valid", 32'(out_valid), 32'd0);
                check("abort_tap_0",     32'(tap_0),     32'd0);
                check("abort_tap_3",     32'(tap_3),     32'd0);
                check("abort_phase",     32'(out_phase), 32'd0);
                check("abort_in_ready",  32'(in_ready),  32'd1);
                return;
            end
            in_valid = (sent < n) && ($urandom_range(99) >= 32'(gap_pct));
            in_data  = (sent < n) ? line_px[sent] : 8'($urandom);
            in_last  = (sent == n - 1);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(1));
            endcase
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                x  = beats / SCALE;
                ph = beats % SCALE;
                check("tap_0",     32'(tap_0),     32'(px_at(x - 1)));
                check("tap_1",     32'(tap_1),     32'(px_at(x)));
                check("tap_2",     32'(tap_2),     32'(px_at(x + 1)));
                check("tap_3",     32'(tap_3),     32'(px_at(x + 2)));
                check("out_phase", 32'(out_phase), 32'(ph));
                check("out_last",  32'(out_last),  32'((x == n - 1) && (ph == SCALE - 1)));
                check("in_ready_in_emit", 32'(in_ready), 32'd0);
                if (out_ready) beats++;
            end else begin
                check("out_last_idle", 32'(out_last), 32'd0);
            end
        end
        check("beats_done", 32'(beats), 32'(total));
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        check("idle_in_ready",  32'(in_ready),  32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_last",  32'(out_last),  32'd0);
        check("reset_phase",     32'(out_phase), 32'd0);
        check("reset_taps",      32'({tap_0, tap_1, tap_2, tap_3}), 32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);

        // Line of five, no backpressure.
        line_px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
        run_line(0, 0, -1);

        // Single-pixel line.
        line_px = '{8'd77};
        run_line(0, 0, -1);

        // Two-pixel line.
        line_px = '{8'd5, 8'd9};
        run_line(0, 0, -1);

        // Toggling downstream backpressure.
        line_px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
        run_line(1, 0, -1);

        // Reset during the third window, then a fresh line.
        line_px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
        run_line(0, 0, 2 * SCALE);
        line_px = '{8'd1, 8'd2, 8'd3};
        run_line(0, 0, -1);

        // Three-pixel line (zero-padding reference case when enabled).
        line_px = '{8'd10, 8'd20, 8'd30};
        run_line(2, 20, -1);

        // Randomised lines, input gaps and backpressure.
        for (int l = 0; l < 24; l++) begin
            int n;
            n = int'($urandom_range(1, 9));
            line_px.delete();
            for (int i = 0; i < n; i++) line_px.push_back(8'($urandom));
            run_line(int'($urandom_range(2)), int'($urandom_range(0, 60)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
